// File: rtl/intersection_controller.sv
// ---------------------------------------------------------------------------
// intersection_controller
//
// Purpose:
//   Fixed-time traffic light controller for a two-way intersection with an
//   optional pedestrian walk phase. The controller cycles
//   NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B
//   and then either returns to NS_GREEN or, if a pedestrian request is
//   pending, inserts a WALK phase (all vehicle heads red) before NS_GREEN.
//   Each phase lasts exactly its parameter count of clock cycles, timed by
//   an 8-bit down-counter that is loaded with (length - 1) on phase entry.
//
// Parameters:
//   GREEN_CYC  - green phase length in cycles (1..255)
//   YELLOW_CYC - yellow phase length in cycles (1..255)
//   ALLRED_CYC - all-red clearance length in cycles (1..255)
//   WALK_CYC   - pedestrian walk length in cycles (1..255)
//
// Ports:
//   clk      in   1  single clock, rising edge active
//   reset_n  in   1  asynchronous active-low reset
//   ped_req  in   1  pedestrian request, level-sampled every cycle
//   color_ns out  2  north-south head: 00 red, 10 yellow, 01 green
//   color_ew out  2  east-west head, same encoding
//   walk     out  1  pedestrian walk indication
//   phase    out  3  current state code (debug)
//
// Configuration macro:
//   PED_REQ_EN - when defined, builds the sticky pedestrian request flag,
//                the WALK state and the walk output decode. When undefined,
//                ped_req is ignored, walk is tied low, ALLRED_B always
//                returns to NS_GREEN and code 6 is handled as illegal.
// ---------------------------------------------------------------------------
module intersection_controller #(
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ped_req,
    output logic [1:0] color_ns,
    output logic [1:0] color_ew,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        WALK      = 3'd6
    } state_e;

    localparam logic [1:0] HEAD_RED    = 2'b00;
    localparam logic [1:0] HEAD_GREEN  = 2'b01;
    localparam logic [1:0] HEAD_YELLOW = 2'b10;

    // Counter reload values: a phase of length N loads N-1 so that it
    // spends exactly N cycles in the state (a length of 1 loads 0).
    localparam logic [7:0] GREEN_LOAD  = 8'(GREEN_CYC - 1);
    localparam logic [7:0] YELLOW_LOAD = 8'(YELLOW_CYC - 1);
    localparam logic [7:0] ALLRED_LOAD = 8'(ALLRED_CYC - 1);
`ifdef PED_REQ_EN
    localparam logic [7:0] WALK_LOAD   = 8'(WALK_CYC - 1);
`endif

    state_e     state_q;
    state_e     state_d;
    logic [7:0] count_q;
    logic [7:0] count_d;

`ifdef PED_REQ_EN
    logic       ped_pending_q;
    logic       ped_pending_d;
    logic       walk_wanted;
`else
    logic       unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    // State register: reset forces NS_GREEN with a full green count and
    // drops any pending pedestrian request, without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= NS_GREEN;
            count_q <= GREEN_LOAD;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

`ifdef PED_REQ_EN
    // Sticky pedestrian request flag, held until the WALK phase begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pending_q <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
        end
    end

    // A request arriving in the very last ALLRED_B cycle is honoured for
    // that same exit decision, so the live input is OR'ed with the flag.
    assign walk_wanted = ped_pending_q | ped_req;
`endif

    // Next-state logic: each state counts down and, in the cycle the
    // counter reads zero, moves on and reloads the counter for the
    // successor's length. Unknown codes fall back to NS_GREEN.
    always_comb begin
        state_d = state_q;
        count_d = count_q - 8'd1;

        case (state_q)
            NS_GREEN: begin
                if (count_q == 8'd0) begin
                    state_d = NS_YELLOW;
                    count_d = YELLOW_LOAD;
                end
            end
            NS_YELLOW: begin
                if (count_q == 8'd0) begin
                    state_d = ALLRED_A;
                    count_d = ALLRED_LOAD;
                end
            end
            ALLRED_A: begin
                if (count_q == 8'd0) begin
                    state_d = EW_GREEN;
                    count_d = GREEN_LOAD;
                end
            end
            EW_GREEN: begin
                if (count_q == 8'd0) begin
                    state_d = EW_YELLOW;
                    count_d = YELLOW_LOAD;
                end
            end
            EW_YELLOW: begin
                if (count_q == 8'd0) begin
                    state_d = ALLRED_B;
                    count_d = ALLRED_LOAD;
                end
            end
            ALLRED_B: begin
                if (count_q == 8'd0) begin
`ifdef PED_REQ_EN
                    if (walk_wanted) begin
                        state_d = WALK;
                        count_d = WALK_LOAD;
                    end else begin
                        state_d = NS_GREEN;
                        count_d = GREEN_LOAD;
                    end
`else
                    state_d = NS_GREEN;
                    count_d = GREEN_LOAD;
`endif
                end
            end
`ifdef PED_REQ_EN
            WALK: begin
                if (count_q == 8'd0) begin
                    state_d = NS_GREEN;
                    count_d = GREEN_LOAD;
                end
            end
`endif
            default: begin
                state_d = NS_GREEN;
                count_d = GREEN_LOAD;
            end
        endcase
    end

`ifdef PED_REQ_EN
    // Pending-flag update: requests outside WALK latch the flag; entering
    // WALK consumes it, and requests made during WALK are ignored.
    always_comb begin
        ped_pending_d = ped_pending_q;
        if (state_q != WALK && ped_req) begin
            ped_pending_d = 1'b1;
        end
        if (state_d == WALK && state_q != WALK) begin
            ped_pending_d = 1'b0;
        end
    end
`endif

    // Moore output decode: heads and walk depend on the state alone.
    // Only one direction is ever given a non-red aspect.
    always_comb begin
        color_ns = HEAD_RED;
        color_ew = HEAD_RED;
        walk     = 1'b0;
        phase    = state_q;

        case (state_q)
            NS_GREEN:  color_ns = HEAD_GREEN;
            NS_YELLOW: color_ns = HEAD_YELLOW;
            EW_GREEN:  color_ew = HEAD_GREEN;
            EW_YELLOW: color_ew = HEAD_YELLOW;
`ifdef PED_REQ_EN
            WALK:      walk     = 1'b1;
`endif
            default: begin
                color_ns = HEAD_RED;
                color_ew = HEAD_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_intersection_controller.sv
// ---------------------------------------------------------------------------
// tb_intersection_controller
//
// Purpose:
//   Self-checking bench for intersection_controller. Two instances run side
//   by side from the same stimulus: one with default phase lengths and one
//   with every phase length set to 1. A reference model of the light
//   schedule (elapsed-cycle timing per phase, sticky request flag) predicts
//   the visible outputs each cycle; predictions are queued by the stimulus
//   process and popped and compared by a separate monitor on the falling
//   clock edge.
//
// Honours PED_REQ_EN the same way as the design, so the expected schedule
// includes WALK phases only in that build.
// ---------------------------------------------------------------------------
module tb_intersection_controller;

`ifdef PED_REQ_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       ped_req;

    logic [1:0] color_ns_a;
    logic [1:0] color_ew_a;
    logic       walk_a;
    logic [2:0] phase_a;

    logic [1:0] color_ns_b;
    logic [1:0] color_ew_b;
    logic       walk_b;
    logic [2:0] phase_b;

    int checks   = 0;
    int failures = 0;

    // Expected word layout: {phase[2:0], ns[1:0], ew[1:0], walk}
    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];

    // Reference model state per instance (0 = default, 1 = all-ones)
    int m_state[2];
    int m_elapsed[2];
    bit m_pending[2];

    intersection_controller dut_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .ped_req  (ped_req),
        .color_ns (color_ns_a),
        .color_ew (color_ew_a),
        .walk     (walk_a),
        .phase    (phase_a)
    );

    intersection_controller #(
        .GREEN_CYC  (1),
        .YELLOW_CYC (1),
        .ALLRED_CYC (1),
        .WALK_CYC   (1)
    ) dut_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .ped_req  (ped_req),
        .color_ns (color_ns_b),
        .color_ew (color_ew_b),
        .walk     (walk_b),
        .phase    (phase_b)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Phase lengths from the schedule: default build vs all-ones build.
    function automatic int phaseLen(input int u, input int st);
        if (u == 1) return 1;
        case (st)
            0: return 8;
            1: return 3;
            2: return 2;
            3: return 8;
            4: return 3;
            5: return 2;
            6: return 5;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] expected(input int u);
        logic [2:0] ph;
        logic [1:0] ns;
        logic [1:0] ew;
        logic       wk;
        ph = 3'(m_state[u]);
        ns = (m_state[u] == 0) ? 2'b01 : (m_state[u] == 1) ? 2'b10 : 2'b00;
        ew = (m_state[u] == 3) ? 2'b01 : (m_state[u] == 4) ? 2'b10 : 2'b00;
        wk = (m_state[u] == 6);
        return {ph, ns, ew, wk};
    endfunction

    task automatic modelReset(input int u);
        m_state[u]   = 0;
        m_elapsed[u] = 0;
        m_pending[u] = 1'b0;
    endtask

    // One clock edge of the light schedule with the request seen this cycle.
    task automatic modelStep(input int u, input logic req);
        bit pend_now;
        pend_now = m_pending[u] || (PED_EN && req && m_state[u] != 6);
        m_elapsed[u] = m_elapsed[u] + 1;
        if (m_elapsed[u] >= phaseLen(u, m_state[u])) begin
            m_elapsed[u] = 0;
            if (m_state[u] == 5)      m_state[u] = (PED_EN && pend_now) ? 6 : 0;
            else if (m_state[u] == 6) m_state[u] = 0;
            else                      m_state[u] = m_state[u] + 1;
            if (m_state[u] == 6) pend_now = 1'b0;
        end
        m_pending[u] = pend_now;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s at t=%0t: actual=%h required=%h",
                     name, $time, actual, required);
        end
    endtask

    // One cycle of stimulus: after the edge, queue what each DUT should show
    // this cycle, drive the new inputs, then advance the model.
    task automatic applyStimulus(input logic req, input logic rst_val);
        @(posedge clk);
        #1;
        ped_req = req;
        reset_n = rst_val;
        if (!rst_val) begin
            modelReset(0);
            modelReset(1);
        end
        exp_q_a.push_back(expected(0));
        exp_q_b.push_back(expected(1));
        if (rst_val) begin
            modelStep(0, req);
            modelStep(1, req);
        end
    endtask

    // Monitor: compare queued predictions against the DUTs mid-cycle, and
    // check that neither instance ever shows two non-red heads at once.
    always @(negedge clk) begin
        if (exp_q_a.size() > 0) begin
            checkOutput("dut_a_outputs", {phase_a, color_ns_a, color_ew_a, walk_a},
                        exp_q_a.pop_front());
            checkOutput("dut_a_exclusive",
                        {7'b0, (color_ns_a != 2'b00) && (color_ew_a != 2'b00)}, 8'h00);
        end
        if (exp_q_b.size() > 0) begin
            checkOutput("dut_b_outputs", {phase_b, color_ns_b, color_ew_b, walk_b},
                        exp_q_b.pop_front());
            checkOutput("dut_b_exclusive",
                        {7'b0, (color_ns_b != 2'b00) && (color_ew_b != 2'b00)}, 8'h00);
        end
    end

    initial begin
        int guard;
        reset_n = 1'b0;
        ped_req = 1'b0;
        modelReset(0);
        modelReset(1);

        // Reset held, then released; plain cycling without requests
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1);

        // Single-cycle request pulse during EW_GREEN
        guard = 0;
        while (m_state[0] != 3 && guard < 100) begin
            applyStimulus(1'b0, 1'b1);
            guard++;
        end
        checkOutput("locate_ew_green", {7'b0, guard < 100}, 8'h01);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1);

        // Request held for 40 cycles starting at the top of NS_GREEN
        guard = 0;
        while (!(m_state[0] == 0 && m_elapsed[0] == 0) && guard < 100) begin
            applyStimulus(1'b0, 1'b1);
            guard++;
        end
        checkOutput("locate_ns_green", {7'b0, guard < 100}, 8'h01);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1);

        // Request only in the final cycle of ALLRED_B
        guard = 0;
        while (!(m_state[0] == 5 && m_elapsed[0] == phaseLen(0, 5) - 1 && !m_pending[0])
               && guard < 100) begin
            applyStimulus(1'b0, 1'b1);
            guard++;
        end
        checkOutput("locate_allred_b_last", {7'b0, guard < 100}, 8'h01);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1);

        // Sparse random requests
        for (int i = 0; i < 200; i++) applyStimulus(($urandom_range(0, 7) == 0), 1'b1);
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1);

        // Reset mid EW_YELLOW with a request pending
        guard = 0;
        while (m_state[0] != 3 && guard < 100) begin
            applyStimulus(1'b0, 1'b1);
            guard++;
        end
        applyStimulus(1'b1, 1'b1);
        while (!(m_state[0] == 4 && m_elapsed[0] == 1) && guard < 200) begin
            applyStimulus(1'b0, 1'b1);
            guard++;
        end
        checkOutput("locate_ew_yellow", {7'b0, guard < 200}, 8'h01);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1);

        // Let the monitor drain the queues
        repeat (2) @(negedge clk);
        #1;
        checkOutput("drain_a", 8'(exp_q_a.size()), 8'h00);
        checkOutput("drain_b", 8'(exp_q_b.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intersection_controller.md
INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

Interface
REQ-001 The block SHALL have parameter GREEN_CYC, default 8, giving the green phase length in clock cycles, legal range 1..255.
REQ-002 The block SHALL have parameter YELLOW_CYC, default 3, giving the yellow phase length in clock cycles, legal range 1..255.
REQ-003 The block SHALL have parameter ALLRED_CYC, default 2, giving the all-red clearance length in clock cycles, legal range 1..255.
REQ-004 The block SHALL have parameter WALK_CYC, default 5, giving the pedestrian walk length in clock cycles, legal range 1..255.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port ped_req, input, 1 bit: pedestrian request, level-sampled every cycle.
REQ-008 The block SHALL have port color_ns, output, 2 bits: north-south signal head; 00 red, 10 yellow, 01 green; 11 never driven.
REQ-009 The block SHALL have port color_ew, output, 2 bits: east-west signal head, same encoding as color_ns.
REQ-010 The block SHALL have port walk, output, 1 bit: pedestrian walk indication.
REQ-011 The block SHALL have port phase, output, 3 bits: current FSM state code for debug.

Function
REQ-012 The FSM SHALL have states and codes NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, WALK=6; code 7 is unused.
REQ-013 Outputs SHALL decode from state alone (Moore): NS_GREEN gives ns=01, ew=00; NS_YELLOW gives ns=10, ew=00; EW_GREEN gives ns=00, ew=01; EW_YELLOW gives ns=00, ew=10; ALLRED_A, ALLRED_B and WALK give both 00; walk=1 only in WALK.
REQ-014 An 8-bit down-counter SHALL load (phase length - 1) on entry to each state, decrement each cycle, and advance the state in the cycle it reads 0, so each state lasts exactly its parameter count of cycles.
REQ-015 The transition order SHALL be NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B -> (WALK if a pedestrian request is pending, else NS_GREEN); WALK -> NS_GREEN.
REQ-016 A phase length of 1 SHALL produce a one-cycle state, with the counter loading 0 and exiting on the next edge.
REQ-017 ped_req=1 in any state other than WALK SHALL set a sticky ped_pending flag on the next edge; ped_req held for many cycles SHALL be equivalent to a single pulse.
REQ-018 ped_req=1 in the final cycle of ALLRED_B SHALL count as pending for that same exit decision.
REQ-019 ped_pending SHALL clear on entry to WALK; ped_req asserted during WALK SHALL be ignored.
REQ-020 The two directions SHALL never be non-red at the same time, and at least one ALLRED or WALK state SHALL always separate any yellow from the opposite green.
REQ-021 An illegal state code (7) SHALL recover to NS_GREEN with a freshly loaded counter on the next edge.

Reset
REQ-022 reset_n=0 SHALL immediately, without waiting for a clock edge, force state NS_GREEN, counter GREEN_CYC-1 and ped_pending 0, giving outputs color_ns=01, color_ew=00, walk=0, phase=0.
REQ-023 Reset asserted mid-phase SHALL discard the remaining count and any pending request; after reset_n rises, NS_GREEN SHALL last a full GREEN_CYC cycles.

Configuration
REQ-024 Macro PED_REQ_EN defined SHALL compile in the ped_pending flag, the WALK state and the walk decode, exactly as described above.
REQ-025 Without PED_REQ_EN, the ped_req port SHALL remain present but be ignored, walk SHALL be tied 0, ALLRED_B SHALL always exit to NS_GREEN, and WALK SHALL be treated as an illegal state per REQ-021.

Verification
REQ-026 Use defaults with ped_req=0 and release reset: phase sequence 0(8 cycles), 1(3), 2(2), 3(8), 4(3), 5(2), then back to 0; period is 26 cycles; colors match REQ-013.
REQ-027 Apply a one-cycle ped_req pulse during EW_GREEN: after ALLRED_B, WALK lasts 5 cycles with walk=1 and both heads 00, then NS_GREEN; the following cycle has no WALK.
REQ-028 Hold ped_req=1 for 40 cycles starting in NS_GREEN: exactly one WALK is inserted per cycle, and pulses during WALK create no second WALK.
REQ-029 Assert ped_req only in the last cycle of ALLRED_B: WALK is entered on the next edge.
REQ-030 Assert reset_n=0 asynchronously mid-EW_YELLOW with a request pending: outputs become ns=01, ew=00, walk=0 before the next edge; after release, NS_GREEN lasts 8 cycles and no WALK occurs.
REQ-031 Set GREEN_CYC=YELLOW_CYC=ALLRED_CYC=WALK_CYC=1 with PED_REQ_EN undefined: every state lasts 1 cycle, the period is 6 cycles, walk stays 0, and no cycle has both heads non-red.
